fetch_stage_ctrl: RTL and testbench

Instruction-fetch front end that consumes the hazard unit's stall/flush/redirect controls. It owns the PC, drives a single-outstanding request/grant/response handshake to instruction memory, and loads the IF/ID pipeline register. A 1-entry skid buffer and a drop state keep fetched instructions correct across stalls and branch/jump redirects.

---
 rtl/fetch_stage_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch front end: PC, single-outstanding imem handshake, 1-entry skid and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating bubble_cnt / drop_cnt outputs.
module fetch_stage_ctrl #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pcstall,
    input  logic                   IF_IDstall,
    input  logic                   flushIF_ID,
    input  logic                   PCSrc,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [PC_WIDTH-1:0]    jump_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instrD,
    output logic [PC_WIDTH-1:0]    pcD,
    output logic [PC_WIDTH-1:0]    pc_plus1D,
    output logic                   validD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]            bubble_cnt,
    output logic [15:0]            drop_cnt
`endif
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ISSUE, WAIT, DRAIN} state_t;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pcF;
    logic [PC_WIDTH-1:0]    pc_inflight;
    logic [PC_WIDTH-1:0]    skid_pc;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic                   skid_full;
    logic                   live;

    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   hold;
    logic                   accept;
    logic                   rsp_take;
    logic                   skid_avail;
    logic                   avail;

    assign redirect    = PCSrc | jump;
    assign redirect_pc = PCSrc ? branch_target : jump_target;
    assign hold        = pcstall | IF_IDstall;

    // live keeps the request low for the whole reset and the first cycle after it
    assign imem_req    = live & (state == ISSUE) & ~skid_full & ~pcstall;
    assign imem_addr   = pcF;
    assign accept      = imem_req & imem_gnt;

    // A redirect makes both the arriving response and the skid entry wrong-path
    assign rsp_take    = (state == WAIT) & imem_rvalid & ~redirect;
    assign skid_avail  = skid_full & ~redirect;
    assign avail       = skid_avail | rsp_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ISSUE;
            pcF         <= RESET_PC;
            pc_inflight <= '0;
            live        <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept)
                pc_inflight <= pcF;
            if (redirect)
                pcF <= redirect_pc;
            else if (accept)
                pcF <= pcF + PC_ONE;
            case (state)
                ISSUE: if (accept) state <= redirect ? DRAIN : WAIT;
                // a response landing with the redirect is simply dropped, nothing left to drain
                WAIT: begin
                    if (imem_rvalid)
                        state <= ISSUE;
                    else if (redirect)
                        state <= DRAIN;
                end
                DRAIN: if (imem_rvalid) state <= ISSUE;
                default: state <= ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_full  <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            instrD     <= NOP_INSTR;
            pcD        <= '0;
            pc_plus1D  <= '0;
            validD     <= 1'b0;
        end else if (flushIF_ID) begin
            validD    <= 1'b0;
            instrD    <= NOP_INSTR;
            skid_full <= 1'b0;
        end else if (hold) begin
            if (redirect) begin
                skid_full <= 1'b0;
            end else if (rsp_take) begin
                skid_full  <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= pc_inflight;
            end
        end else if (avail) begin
            validD    <= 1'b1;
            skid_full <= 1'b0;
            if (skid_avail) begin
                instrD    <= skid_instr;
                pcD       <= skid_pc;
                pc_plus1D <= skid_pc + PC_ONE;
            end else begin
                instrD    <= imem_rdata;
                pcD       <= pc_inflight;
                pc_plus1D <= pc_inflight + PC_ONE;
            end
        end else begin
            validD    <= 1'b0;
            instrD    <= NOP_INSTR;
            skid_full <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (!flushIF_ID && !hold && !avail && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
            if (imem_rvalid && (state == DRAIN || (state == WAIT && flushIF_ID)) &&
                drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl with a small imem model (programmable grant and response latency).
module tb_fetch_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcstall, IF_IDstall, flushIF_ID, PCSrc, jump;
    logic [15:0] branch_target, jump_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] instrD, pcD, pc_plus1D;
    logic        validD;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] bubble_cnt, drop_cnt;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    int          lat = 1;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0;
    logic [15:0] b0;

    fetch_stage_ctrl dut (
        .clk(clk), .rst(rst), .pcstall(pcstall), .IF_IDstall(IF_IDstall),
        .flushIF_ID(flushIF_ID), .PCSrc(PCSrc), .jump(jump),
        .branch_target(branch_target), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrD(instrD), .pcD(pcD), .pc_plus1D(pc_plus1D), .validD(validD)
`ifdef FETCH_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] f(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    // imem model: responds lat cycles after a grant; not reset, so a pre-reset request still answers
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (imem_req && imem_gnt) begin
            if (lat <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= f(imem_addr);
            end else begin
                pend_cnt  <= lat - 1;
                pend_addr <= imem_addr;
            end
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= f(pend_addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task test_reset;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
        n_chk++; if (validD !== 1'b0) begin n_err++; $display("FAIL rst_validD got %b exp 0", validD); end
        n_chk++; if (instrD !== 16'h0) begin n_err++; $display("FAIL rst_instrD got %h exp 0000", instrD); end
        n_chk++; if (pcD !== 16'h0) begin n_err++; $display("FAIL rst_pcD got %h exp 0000", pcD); end
        n_chk++; if (pc_plus1D !== 16'h0) begin n_err++; $display("FAIL rst_pc_plus1D got %h exp 0000", pc_plus1D); end
`ifdef FETCH_PERF_CNT_EN
        n_chk++; if (bubble_cnt !== 16'h0) begin n_err++; $display("FAIL rst_bubble_cnt got %h exp 0000", bubble_cnt); end
`endif
        rst = 1'b1;
    endtask

    task test_basic;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req got %b exp 1", imem_req); end
            n_chk++; if (imem_addr !== 16'(k)) begin n_err++; $display("FAIL basic_addr got %h exp %h", imem_addr, 16'(k)); end
            if (k > 0) begin
                n_chk++; if (validD !== 1'b1) begin n_err++; $display("FAIL basic_validD got %b exp 1", validD); end
                n_chk++; if (pcD !== 16'(k-1)) begin n_err++; $display("FAIL basic_pcD got %h exp %h", pcD, 16'(k-1)); end
                n_chk++; if (instrD !== f(16'(k-1))) begin n_err++; $display("FAIL basic_instrD got %h exp %h", instrD, f(16'(k-1))); end
                n_chk++; if (pc_plus1D !== 16'(k)) begin n_err++; $display("FAIL basic_pc_plus1D got %h exp %h", pc_plus1D, 16'(k)); end
            end
            @(negedge clk);
            n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_wait_req got %b exp 0", imem_req); end
            n_chk++; if (validD !== 1'b0) begin n_err++; $display("FAIL basic_bubble got %b exp 0", validD); end
        end
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'h2 || instrD !== 16'hC3C1) begin
            n_err++; $display("FAIL basic_last got v=%b pc=%h i=%h exp v=1 pc=0002 i=c3c1", validD, pcD, instrD); end
    endtask

    task test_pcstall;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'h3) begin n_err++; $display("FAIL stall_pre got v=%b pc=%h exp v=1 pc=0003", validD, pcD); end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h4) begin n_err++; $display("FAIL stall_issue4 got r=%b a=%h exp r=1 a=0004", imem_req, imem_addr); end
        IF_IDstall = 1'b1;
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'h3) begin n_err++; $display("FAIL stall_hold0 got v=%b pc=%h exp v=1 pc=0003", validD, pcD); end
        pcstall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req%0d got %b exp 0", i, imem_req); end
            n_chk++; if (validD !== 1'b1 || pcD !== 16'h3 || instrD !== 16'hC3C0) begin
                n_err++; $display("FAIL stall_hold%0d got v=%b pc=%h i=%h exp v=1 pc=0003 i=c3c0", i, validD, pcD, instrD); end
        end
        pcstall = 1'b0;
        IF_IDstall = 1'b0;
        #1;
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_skidfull_req got %b exp 0", imem_req); end
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'h4 || instrD !== 16'hC3C7 || pc_plus1D !== 16'h5) begin
            n_err++; $display("FAIL stall_skid_load got v=%b pc=%h i=%h p1=%h exp v=1 pc=0004 i=c3c7 p1=0005", validD, pcD, instrD, pc_plus1D); end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h5) begin n_err++; $display("FAIL stall_next_addr got r=%b a=%h exp r=1 a=0005", imem_req, imem_addr); end
        @(negedge clk);
        n_chk++; if (validD !== 1'b0) begin n_err++; $display("FAIL stall_nodup got %b exp 0", validD); end
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'h5) begin n_err++; $display("FAIL stall_after got v=%b pc=%h exp v=1 pc=0005", validD, pcD); end
    endtask

    task test_redirect;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h7) begin n_err++; $display("FAIL redir_issue7 got r=%b a=%h exp r=1 a=0007", imem_req, imem_addr); end
        lat = 2;
        @(negedge clk);
        PCSrc = 1'b1;
        branch_target = 16'h0040;
        @(negedge clk);
        PCSrc = 1'b0;
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_drain_req got %b exp 0", imem_req); end
        @(negedge clk);
        n_chk++; if (validD !== 1'b0) begin n_err++; $display("FAIL redir_dropped got %b exp 0", validD); end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_err++; $display("FAIL redir_addr got r=%b a=%h exp r=1 a=0040", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_chk++; if (drop_cnt !== 16'h1) begin n_err++; $display("FAIL redir_drop_cnt got %h exp 0001", drop_cnt); end
`endif
        lat = 1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'h0040 || instrD !== 16'hC383 || pc_plus1D !== 16'h0041) begin
            n_err++; $display("FAIL redir_target got v=%b pc=%h i=%h p1=%h exp v=1 pc=0040 i=c383 p1=0041", validD, pcD, instrD, pc_plus1D); end
    endtask

    task test_priority;
        imem_gnt = 1'b0;
        PCSrc = 1'b1;
        jump = 1'b1;
        branch_target = 16'h0010;
        jump_target = 16'h0020;
        @(negedge clk);
        PCSrc = 1'b0;
        jump = 1'b0;
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin n_err++; $display("FAIL prio_addr got r=%b a=%h exp r=1 a=0010", imem_req, imem_addr); end
    endtask

    task test_reset_mid;
        imem_gnt = 1'b1;
        lat = 3;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_wait_req got %b exp 0", imem_req); end
        rst = 1'b0;
        #1;
        n_chk++; if (pcD !== 16'h0 || pc_plus1D !== 16'h0) begin n_err++; $display("FAIL rmid_pcD got pc=%h p1=%h exp 0000 0000", pcD, pc_plus1D); end
        n_chk++; if (validD !== 1'b0 || instrD !== 16'h0 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL rmid_outs got v=%b i=%h r=%b exp 0 0000 0", validD, instrD, imem_req); end
`ifdef FETCH_PERF_CNT_EN
        n_chk++; if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL rmid_drop_cnt got %h exp 0000", drop_cnt); end
`endif
        @(negedge clk);
        rst = 1'b1;
        lat = 1;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin n_err++; $display("FAIL rmid_first got r=%b a=%h exp r=1 a=0000", imem_req, imem_addr); end
        @(negedge clk);
        n_chk++; if (validD !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_stray got v=%b r=%b exp 0 0", validD, imem_req); end
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'h0 || instrD !== 16'hC3C3) begin
            n_err++; $display("FAIL rmid_deliver got v=%b pc=%h i=%h exp v=1 pc=0000 i=c3c3", validD, pcD, instrD); end
    endtask

    task test_gnt_wrap;
        imem_gnt = 1'b0;
        jump = 1'b1;
        jump_target = 16'hFFFF;
        @(negedge clk);
        jump = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        b0 = bubble_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin
                n_err++; $display("FAIL gnt_stable%0d got r=%b a=%h exp r=1 a=ffff", i, imem_req, imem_addr); end
            n_chk++; if (validD !== 1'b0) begin n_err++; $display("FAIL gnt_bubble%0d got %b exp 0", i, validD); end
            @(negedge clk);
        end
`ifdef FETCH_PERF_CNT_EN
        n_chk++; if (16'(bubble_cnt - b0) !== 16'd5) begin n_err++; $display("FAIL gnt_bubble_cnt got %0d exp 5", 16'(bubble_cnt - b0)); end
`endif
        imem_gnt = 1'b1;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL wrap_wait_req got %b exp 0", imem_req); end
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'hFFFF || pc_plus1D !== 16'h0000 || instrD !== 16'h3C3C) begin
            n_err++; $display("FAIL wrap_deliver got v=%b pc=%h p1=%h i=%h exp v=1 pc=ffff p1=0000 i=3c3c", validD, pcD, pc_plus1D, instrD); end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr got r=%b a=%h exp r=1 a=0000", imem_req, imem_addr); end
    endtask

    task test_flush;
        @(negedge clk);
        flushIF_ID = 1'b1;
        @(negedge clk);
        flushIF_ID = 1'b0;
        n_chk++; if (validD !== 1'b0) begin n_err++; $display("FAIL flush_validD got %b exp 0", validD); end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h1) begin n_err++; $display("FAIL flush_next got r=%b a=%h exp r=1 a=0001", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_chk++; if (drop_cnt !== 16'h1) begin n_err++; $display("FAIL flush_drop_cnt got %h exp 0001", drop_cnt); end
`endif
        @(negedge clk);
        n_chk++; if (validD !== 1'b0) begin n_err++; $display("FAIL flush_no_buffer got %b exp 0", validD); end
        @(negedge clk);
        n_chk++; if (validD !== 1'b1 || pcD !== 16'h1 || instrD !== 16'hC3C2) begin
            n_err++; $display("FAIL flush_after got v=%b pc=%h i=%h exp v=1 pc=0001 i=c3c2", validD, pcD, instrD); end
    endtask

    initial begin
        rst = 1'b0;
        pcstall = 1'b0;
        IF_IDstall = 1'b0;
        flushIF_ID = 1'b0;
        PCSrc = 1'b0;
        jump = 1'b0;
        branch_target = 16'h0;
        jump_target = 16'h0;
        imem_gnt = 1'b1;
        b0 = 16'h0;
        test_reset;
        test_basic;
        test_pcstall;
        test_redirect;
        test_priority;
        test_reset_mid;
        test_gnt_wrap;
        test_flush;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
